wt_dcache_inval_sched: RTL and testbench

//  Schedules bus invalidations into the write-through L1 D$. Buffers line invalidations, merges duplicate lines and absorbs whole-cache invalidations.

---
 rtl/wt_dcache_inval_sched_pkg.sv | 15 +
 rtl/wt_dcache_inval_sched_if.sv | 26 ++
 rtl/wt_dcache_inval_fifo.sv | 78 +++++++
 rtl/wt_dcache_inval_sched.sv | 109 ++++++++++
 tb/tb_wt_dcache_inval_sched.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/wt_dcache_inval_sched_pkg.sv
// Shared types for the D$ invalidation scheduler: line-address type and FSM states.
// Line address drops the cache-line offset bits of the physical address.
package wt_dcache_inval_sched_pkg;
    localparam int unsigned PLEN                = 56;
    localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
    localparam int unsigned LINE_W              = PLEN - DCACHE_OFFSET_WIDTH;

    typedef logic [LINE_W-1:0] inv_line_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ALL   = 2'd2
    } inv_sched_state_e;
endpackage

// File: rtl/wt_dcache_inval_sched_if.sv
// Bus-side request, wt_dcache_inval req/ack and miss-unit invalidate-all handshakes.
// slave = scheduler view, master = surrounding environment view.
interface wt_dcache_inval_sched_if;
    import wt_dcache_inval_sched_pkg::*;

    logic            bus_inv_vld_i;
    logic            bus_inv_all_i;
    logic [PLEN-1:0] bus_inv_paddr_i;
    logic            bus_inv_rdy_o;
    logic            mem_inv_req_o;
    logic [PLEN-1:0] mem_inv_paddr_o;
    logic            mem_inv_ack_i;
    logic            inv_all_req_o;
    logic            inv_all_ack_i;
    logic            busy_o;

    modport slave (
        input  bus_inv_vld_i, bus_inv_all_i, bus_inv_paddr_i, mem_inv_ack_i, inv_all_ack_i,
        output bus_inv_rdy_o, mem_inv_req_o, mem_inv_paddr_o, inv_all_req_o, busy_o
    );

    modport master (
        output bus_inv_vld_i, bus_inv_all_i, bus_inv_paddr_i, mem_inv_ack_i, inv_all_ack_i,
        input  bus_inv_rdy_o, mem_inv_req_o, mem_inv_paddr_o, inv_all_req_o, busy_o
    );
endinterface

// File: rtl/wt_dcache_inval_fifo.sv
// Line-address queue with per-entry valid bits, parallel match and flush; push visible next cycle.
// No internal backpressure: caller must not push when full; flush may keep the in-flight head.
module wt_dcache_inval_fifo
    import wt_dcache_inval_sched_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  inv_line_t        i_push_dat,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic             i_keep_head,
    input  inv_line_t        i_cmp_dat,
    output logic             o_match,
    output inv_line_t        o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full
);
    inv_line_t        r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] w_vld_nxt;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    // A flush coinciding with the head's pop leaves nothing behind.
    always_comb begin
        w_vld_nxt = r_vld;
        if (i_flush) begin
            w_vld_nxt = '0;
            if (i_keep_head && !i_pop) w_vld_nxt[r_rd_ptr] = 1'b1;
        end else begin
            if (i_pop)  w_vld_nxt[r_rd_ptr] = 1'b0;
            if (i_push) w_vld_nxt[r_wr_ptr] = 1'b1;
        end
    end

    always_comb begin
        o_match = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_vld[i] && (r_mem[i] == i_cmp_dat)) o_match = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem    <= '{default: '0};
            r_vld    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_vld <= w_vld_nxt;
            if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
            if (i_flush) begin
                if (i_keep_head && !i_pop) begin
                    r_wr_ptr <= r_rd_ptr + PTR_W'(1);
                    r_count  <= CNT_W'(1);
                end else begin
                    r_rd_ptr <= r_wr_ptr;
                    r_count  <= '0;
                end
            end else begin
                if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
endmodule

// File: rtl/wt_dcache_inval_sched.sv
// Queues/merges bus line invalidations, issues one at a time to wt_dcache_inval, absorbs invalidate-all.
// First request 1 cycle after push, no bubble between acks; rdy drops only when full with no merge.
module wt_dcache_inval_sched
    import wt_dcache_inval_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    wt_dcache_inval_sched_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    inv_sched_state_e r_state;
    inv_sched_state_e w_state_nxt;
    logic             r_all_pend;
    inv_line_t        w_line;
    inv_line_t        w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_match;
    logic             w_full;
    logic             w_rdy;
    logic             w_acc_all;
    logic             w_acc_line;
    logic             w_push;
    logic             w_pop;
    logic             w_more;
    logic             w_unused_off;

    assign w_line       = bus.bus_inv_paddr_i[PLEN-1:DCACHE_OFFSET_WIDTH];
    assign w_unused_off = ^bus.bus_inv_paddr_i[DCACHE_OFFSET_WIDTH-1:0];

    // Ready uses pre-pop fullness so the ack never feeds back into rdy combinationally.
    assign w_rdy      = !w_full | w_match | bus.bus_inv_all_i;
    assign w_acc_all  = bus.bus_inv_vld_i & w_rdy & bus.bus_inv_all_i;
    assign w_acc_line = bus.bus_inv_vld_i & w_rdy & !bus.bus_inv_all_i;
    assign w_push     = w_acc_line & !w_match & !r_all_pend;
    assign w_pop      = (r_state == ISSUE) & bus.mem_inv_ack_i;
    assign w_more     = (w_count > CNT_W'(1)) | w_push;

    wt_dcache_inval_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_push      (w_push),
        .i_push_dat  (w_line),
        .i_pop       (w_pop),
        .i_flush     (w_acc_all),
        .i_keep_head (r_state == ISSUE),
        .i_cmp_dat   (w_line),
        .o_match     (w_match),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_all_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc_all) begin
                r_all_pend <= 1'b1;
            end else if ((r_state == ALL) && bus.inv_all_ack_i) begin
                r_all_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        bus.mem_inv_req_o   = 1'b0;
        bus.mem_inv_paddr_o = '0;
        bus.inv_all_req_o   = 1'b0;
        case (r_state)
            IDLE: begin
                // An all request accepted now empties the queue, so don't start issuing it.
                if (r_all_pend) begin
                    w_state_nxt = ALL;
                end else if ((w_count != '0) && !w_acc_all) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_inv_req_o   = 1'b1;
                bus.mem_inv_paddr_o = {w_head, {DCACHE_OFFSET_WIDTH{1'b0}}};
                if (bus.mem_inv_ack_i) begin
                    if (r_all_pend || w_acc_all) begin
                        w_state_nxt = ALL;
                    end else if (w_more) begin
                        w_state_nxt = ISSUE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            ALL: begin
                bus.inv_all_req_o = 1'b1;
                if (bus.inv_all_ack_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.bus_inv_rdy_o = w_rdy;
    assign bus.busy_o        = (w_count != '0) | (r_state != IDLE) | r_all_pend;
endmodule

// File: tb/tb_wt_dcache_inval_sched.sv
// Directed bench for wt_dcache_inval_sched: single line, merge, full, invalidate-all, wrap, reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge or #1 after an input change.
module tb_wt_dcache_inval_sched;
    localparam int PW = wt_dcache_inval_sched_pkg::PLEN;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wt_dcache_inval_sched_if bus_if ();

    wt_dcache_inval_sched #(.DEPTH(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    task automatic test_reset();
        checks++; if (bus_if.mem_inv_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", bus_if.mem_inv_req_o); end
        checks++; if (bus_if.inv_all_req_o !== 1'b0) begin errors++; $display("FAIL rst_all_req got %b want 0", bus_if.inv_all_req_o); end
        checks++; if (bus_if.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus_if.busy_o); end
        checks++; if (bus_if.bus_inv_rdy_o !== 1'b1) begin errors++; $display("FAIL rst_rdy got %b want 1", bus_if.bus_inv_rdy_o); end
        checks++; if (bus_if.mem_inv_paddr_o !== '0) begin errors++; $display("FAIL rst_paddr got %h want 0", bus_if.mem_inv_paddr_o); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus_if.busy_o !== 1'b0) begin errors++; $display("FAIL rst_rel_busy got %b want 0", bus_if.busy_o); end
    endtask

    task automatic test_single_line();
        bus_if.bus_inv_vld_i   = 1'b1;
        bus_if.bus_inv_all_i   = 1'b0;
        bus_if.bus_inv_paddr_i = 56'h8000_1040;
        #1;
        checks++; if (bus_if.bus_inv_rdy_o !== 1'b1) begin errors++; $display("FAIL t1_rdy got %b want 1", bus_if.bus_inv_rdy_o); end
        @(negedge clk);
        bus_if.bus_inv_vld_i = 1'b0;
        checks++; if (bus_if.mem_inv_req_o !== 1'b0) begin errors++; $display("FAIL t1_req_early got %b want 0", bus_if.mem_inv_req_o); end
        checks++; if (bus_if.busy_o !== 1'b1) begin errors++; $display("FAIL t1_busy got %b want 1", bus_if.busy_o); end
        @(negedge clk);
        checks++; if (bus_if.mem_inv_req_o !== 1'b1) begin errors++; $display("FAIL t1_req got %b want 1", bus_if.mem_inv_req_o); end
        checks++; if (bus_if.mem_inv_paddr_o !== 56'h8000_1040) begin errors++; $display("FAIL t1_paddr got %h want 80001040", bus_if.mem_inv_paddr_o); end
        @(negedge clk);
        checks++; if (bus_if.mem_inv_req_o !== 1'b1) begin errors++; $display("FAIL t1_req_hold got %b want 1", bus_if.mem_inv_req_o); end
        bus_if.mem_inv_ack_i = 1'b1;
        @(negedge clk);
        bus_if.mem_inv_ack_i = 1'b0;
        checks++; if (bus_if.mem_inv_req_o !== 1'b0) begin errors++; $display("FAIL t1_req_done got %b want 0", bus_if.mem_inv_req_o); end
        checks++; if (bus_if.busy_o !== 1'b0) begin errors++; $display("FAIL t1_busy_done got %b want 0", bus_if.busy_o); end
    endtask

    task automatic test_merge();
        logic [PW-1:0] addrs [3];
        addrs[0] = 56'h1000; addrs[1] = 56'h1008; addrs[2] = 56'h1000;
        for (int i = 0; i < 3; i++) begin
            bus_if.bus_inv_vld_i   = 1'b1;
            bus_if.bus_inv_paddr_i = addrs[i];
            #1;
            checks++; if (bus_if.bus_inv_rdy_o !== 1'b1) begin errors++; $display("FAIL t2_rdy%0d got %b want 1", i, bus_if.bus_inv_rdy_o); end
            @(negedge clk);
        end
        bus_if.bus_inv_vld_i = 1'b0;
        checks++; if (bus_if.mem_inv_req_o !== 1'b1) begin errors++; $display("FAIL t2_req got %b want 1", bus_if.mem_inv_req_o); end
        checks++; if (bus_if.mem_inv_paddr_o !== 56'h1000) begin errors++; $display("FAIL t2_paddr got %h want 1000", bus_if.mem_inv_paddr_o); end
        bus_if.mem_inv_ack_i = 1'b1;
        @(negedge clk);
        bus_if.mem_inv_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus_if.mem_inv_req_o !== 1'b0) begin errors++; $display("FAIL t2_extra_req%0d got %b want 0", i, bus_if.mem_inv_req_o); end
            @(negedge clk);
        end
        checks++; if (bus_if.busy_o !== 1'b0) begin errors++; $display("FAIL t2_busy got %b want 0", bus_if.busy_o); end
    endtask

    task automatic test_full();
        logic [PW-1:0] exp_q [4];
        for (int i = 0; i < 4; i++) begin
            bus_if.bus_inv_vld_i   = 1'b1;
            bus_if.bus_inv_paddr_i = PW'((i + 1) * 'h100);
            #1;
            checks++; if (bus_if.bus_inv_rdy_o !== 1'b1) begin errors++; $display("FAIL t3_rdy%0d got %b want 1", i, bus_if.bus_inv_rdy_o); end
            @(negedge clk);
        end
        bus_if.bus_inv_paddr_i = 56'h50C;
        #1;
        checks++; if (bus_if.bus_inv_rdy_o !== 1'b0) begin errors++; $display("FAIL t3_full_rdy got %b want 0", bus_if.bus_inv_rdy_o); end
        @(negedge clk);
        checks++; if (bus_if.mem_inv_paddr_o !== 56'h100) begin errors++; $display("FAIL t3_head got %h want 100", bus_if.mem_inv_paddr_o); end
        bus_if.mem_inv_ack_i = 1'b1;
        #1;
        checks++; if (bus_if.bus_inv_rdy_o !== 1'b0) begin errors++; $display("FAIL t3_rdy_ack got %b want 0", bus_if.bus_inv_rdy_o); end
        @(negedge clk);
        bus_if.mem_inv_ack_i = 1'b0;
        #1;
        checks++; if (bus_if.bus_inv_rdy_o !== 1'b1) begin errors++; $display("FAIL t3_rdy_after got %b want 1", bus_if.bus_inv_rdy_o); end
        @(negedge clk);
        bus_if.bus_inv_vld_i = 1'b0;
        exp_q[0] = 56'h200; exp_q[1] = 56'h300; exp_q[2] = 56'h400; exp_q[3] = 56'h500;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus_if.mem_inv_req_o !== 1'b1 || bus_if.mem_inv_paddr_o !== exp_q[i]) begin
                errors++; $display("FAIL t3_order%0d got req %b paddr %h want req 1 paddr %h", i, bus_if.mem_inv_req_o, bus_if.mem_inv_paddr_o, exp_q[i]);
            end
            bus_if.mem_inv_ack_i = 1'b1;
            @(negedge clk);
        end
        bus_if.mem_inv_ack_i = 1'b0;
        checks++; if (bus_if.busy_o !== 1'b0) begin errors++; $display("FAIL t3_busy got %b want 0", bus_if.busy_o); end
    endtask

    task automatic test_inval_all();
        for (int i = 0; i < 3; i++) begin
            bus_if.bus_inv_vld_i   = 1'b1;
            bus_if.bus_inv_paddr_i = PW'('h1100 + i * 'h100);
            @(negedge clk);
        end
        bus_if.bus_inv_all_i   = 1'b1;
        bus_if.bus_inv_paddr_i = 56'hDEAD0;
        #1;
        checks++; if (bus_if.bus_inv_rdy_o !== 1'b1) begin errors++; $display("FAIL t4_all_rdy got %b want 1", bus_if.bus_inv_rdy_o); end
        checks++; if (bus_if.mem_inv_paddr_o !== 56'h1100) begin errors++; $display("FAIL t4_head got %h want 1100", bus_if.mem_inv_paddr_o); end
        @(negedge clk);
        bus_if.bus_inv_all_i   = 1'b0;
        bus_if.bus_inv_paddr_i = 56'h1400;
        #1;
        checks++; if (bus_if.bus_inv_rdy_o !== 1'b1) begin errors++; $display("FAIL t4_drop_rdy got %b want 1", bus_if.bus_inv_rdy_o); end
        checks++; if (bus_if.mem_inv_req_o !== 1'b1 || bus_if.mem_inv_paddr_o !== 56'h1100) begin
            errors++; $display("FAIL t4_inflight got req %b paddr %h want req 1 paddr 1100", bus_if.mem_inv_req_o, bus_if.mem_inv_paddr_o);
        end
        checks++; if (bus_if.inv_all_req_o !== 1'b0) begin errors++; $display("FAIL t4_all_early got %b want 0", bus_if.inv_all_req_o); end
        @(negedge clk);
        bus_if.bus_inv_vld_i = 1'b0;
        bus_if.mem_inv_ack_i = 1'b1;
        @(negedge clk);
        bus_if.mem_inv_ack_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus_if.inv_all_req_o !== 1'b1 || bus_if.mem_inv_req_o !== 1'b0) begin
                errors++; $display("FAIL t4_all%0d got all %b req %b want all 1 req 0", i, bus_if.inv_all_req_o, bus_if.mem_inv_req_o);
            end
            @(negedge clk);
        end
        bus_if.inv_all_ack_i = 1'b1;
        @(negedge clk);
        bus_if.inv_all_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus_if.mem_inv_req_o !== 1'b0 || bus_if.inv_all_req_o !== 1'b0 || bus_if.busy_o !== 1'b0) begin
                errors++; $display("FAIL t4_quiet%0d got req %b all %b busy %b want 0 0 0", i, bus_if.mem_inv_req_o, bus_if.inv_all_req_o, bus_if.busy_o);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back_wrap();
        int            issued  = 0;
        int            bubbles = 0;
        logic [PW-1:0] exp_a;
        bus_if.mem_inv_ack_i = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (bus_if.mem_inv_req_o === 1'b1) begin
                exp_a = PW'('h2000 + issued * 'h10);
                checks++; if (issued >= 10 || bus_if.mem_inv_paddr_o !== exp_a) begin
                    errors++; $display("FAIL t5_issue%0d got %h want %h", issued, bus_if.mem_inv_paddr_o, exp_a);
                end
                issued++;
            end else if (issued > 0 && issued < 10) begin
                bubbles++;
            end
            bus_if.bus_inv_vld_i   = (c < 10);
            bus_if.bus_inv_paddr_i = PW'('h2000 + c * 'h10);
            if (c < 10) begin
                #1;
                checks++; if (bus_if.bus_inv_rdy_o !== 1'b1) begin errors++; $display("FAIL t5_rdy%0d got %b want 1", c, bus_if.bus_inv_rdy_o); end
            end
            @(negedge clk);
        end
        bus_if.mem_inv_ack_i = 1'b0;
        checks++; if (issued != 10) begin errors++; $display("FAIL t5_count got %0d want 10", issued); end
        checks++; if (bubbles != 0) begin errors++; $display("FAIL t5_bubbles got %0d want 0", bubbles); end
        checks++; if (bus_if.busy_o !== 1'b0) begin errors++; $display("FAIL t5_busy got %b want 0", bus_if.busy_o); end
    endtask

    task automatic test_reset_mid_issue();
        for (int i = 0; i < 3; i++) begin
            bus_if.bus_inv_vld_i   = 1'b1;
            bus_if.bus_inv_paddr_i = PW'('h3000 + i * 'h100);
            @(negedge clk);
        end
        bus_if.bus_inv_vld_i = 1'b0;
        checks++; if (bus_if.mem_inv_req_o !== 1'b1) begin errors++; $display("FAIL t6_pre_req got %b want 1", bus_if.mem_inv_req_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus_if.mem_inv_req_o !== 1'b0 || bus_if.inv_all_req_o !== 1'b0 || bus_if.busy_o !== 1'b0) begin
            errors++; $display("FAIL t6_async got req %b all %b busy %b want 0 0 0", bus_if.mem_inv_req_o, bus_if.inv_all_req_o, bus_if.busy_o);
        end
        checks++; if (bus_if.bus_inv_rdy_o !== 1'b1 || bus_if.mem_inv_paddr_o !== '0) begin
            errors++; $display("FAIL t6_async_rdy got rdy %b paddr %h want 1 0", bus_if.bus_inv_rdy_o, bus_if.mem_inv_paddr_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.mem_inv_ack_i = 1'b1;
        @(negedge clk);
        bus_if.mem_inv_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus_if.mem_inv_req_o !== 1'b0 || bus_if.busy_o !== 1'b0) begin
                errors++; $display("FAIL t6_after%0d got req %b busy %b want 0 0", i, bus_if.mem_inv_req_o, bus_if.busy_o);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                  = 1'b0;
        bus_if.bus_inv_vld_i   = 1'b0;
        bus_if.bus_inv_all_i   = 1'b0;
        bus_if.bus_inv_paddr_i = '0;
        bus_if.mem_inv_ack_i   = 1'b0;
        bus_if.inv_all_ack_i   = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_line();
        test_merge();
        test_full();
        test_inval_all();
        test_back_to_back_wrap();
        test_reset_mid_issue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
